mem_handshake_responder: RTL and testbench

- Memory-side responder for the datapath's MAR/MDR memory handshake.
- Accepts a request (enable, read/write, size, address, write data), inserts LATENCY wait states, then performs the access on a byte-addressed, big-endian array.
- Raises MFC (memory function complete) and holds it until the initiator drops enable.
- Detects misaligned accesses and reports them instead of performing them.

---
 rtl/mem_handshake_responder_pkg.sv | 30 +++
 rtl/mem_handshake_responder_byte_array.sv | 28 ++
 rtl/mem_handshake_responder.sv | 141 ++++++++++++++
 tb/tb_mem_handshake_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_handshake_responder_pkg.sv
// Shared definitions for the MAR/MDR memory handshake responder:
// size encodings, FSM state type and the alignment check.
package mem_handshake_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Reserved size is always reported as an error.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = |addr_lo;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_handshake_responder_byte_array.sv
// Byte-addressed storage with a 4-lane big-endian write port and 4-byte read port.
// Lane 3 maps to the base address and carries data[31:24]; lane 0 maps to base+3.
module mem_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic [3:0]        lane_we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (lane_we_i[i]) begin
        mem_q[addr_i + ADDR_W'(3 - i)] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = {mem_q[addr_i],
                    mem_q[addr_i + ADDR_W'(1)],
                    mem_q[addr_i + ADDR_W'(2)],
                    mem_q[addr_i + ADDR_W'(3)]};

endmodule

// File: rtl/mem_handshake_responder.sv
// Memory-side responder: captures a request, waits LATENCY cycles, performs the
// big-endian access (or flags misalignment) and holds MFC until enable drops.
module mem_handshake_responder
  import mem_handshake_responder_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              MemEnable,
  input  logic              MemRead,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [31:0]       MemDataIn,
  output logic [31:0]       MemDataOut,
  output logic              MFC,
  output logic              MemErr
);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              rd_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       dout_q;
  logic              mfc_q;
  logic              err_q;

  logic              access;
  logic              bad;
  logic [3:0]        lane_we;
  logic [31:0]       lane_wdata;
  logic [31:0]       rdata;
  logic [31:0]       load_val;

  // WAIT with a zero count is the access step, so LATENCY = 0 passes through it once.
  assign access = (state_q == ST_WAIT) && (cnt_q == '0);
  assign bad    = is_misaligned(size_q, addr_q[1:0]);

  always_comb begin
    lane_we    = '0;
    lane_wdata = '0;
    if (access && !rd_q && !bad) begin
      case (size_q)
        SIZE_BYTE: begin
          lane_we    = 4'b1000;
          lane_wdata = {wdata_q[7:0], 24'h0};
        end
        SIZE_HALF: begin
          lane_we    = 4'b1100;
          lane_wdata = {wdata_q[15:0], 16'h0};
        end
        SIZE_WORD: begin
          lane_we    = 4'b1111;
          lane_wdata = wdata_q;
        end
        default: begin
          lane_we    = '0;
          lane_wdata = '0;
        end
      endcase
    end
  end

  always_comb begin
    load_val = '0;
    case (size_q)
      SIZE_BYTE: load_val = {{24{sgn_q & rdata[31]}}, rdata[31:24]};
      SIZE_HALF: load_val = {{16{sgn_q & rdata[31]}}, rdata[31:16]};
      default:   load_val = rdata;
    endcase
  end

  mem_byte_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i    (Clk),
    .lane_we_i(lane_we),
    .addr_i   (addr_q),
    .wdata_i  (lane_wdata),
    .rdata_o  (rdata)
  );

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MemEnable) begin
            rd_q    <= MemRead;
            size_q  <= MemSize;
            sgn_q   <= MemSigned;
            addr_q  <= MemAddr;
            wdata_q <= MemDataIn;
            cnt_q   <= 4'(LATENCY);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            mfc_q   <= 1'b1;
            err_q   <= bad;
            if (rd_q && !bad) begin
              dout_q <= load_val;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          if (!MemEnable) begin
            state_q <= ST_IDLE;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MemDataOut = dout_q;
  assign MFC        = mfc_q;
  assign MemErr     = err_q;

endmodule

// File: tb/tb_mem_handshake_responder.sv
// Directed bench for mem_handshake_responder: LATENCY = 2 instance plus a LATENCY = 0 instance.
module tb_mem_handshake_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        en, rd, sg;
  logic [1:0]  sz;
  logic [7:0]  addr;
  logic [31:0] din, dout;
  logic        mfc, err;

  logic        en0, rd0, sg0;
  logic [1:0]  sz0;
  logic [7:0]  addr0;
  logic [31:0] din0, dout0;
  logic        mfc0, err0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_handshake_responder #(.ADDR_W(8), .LATENCY(2)) u_dut (
    .Clk(clk), .Clr(rst_n), .MemEnable(en), .MemRead(rd), .MemSize(sz),
    .MemSigned(sg), .MemAddr(addr), .MemDataIn(din), .MemDataOut(dout),
    .MFC(mfc), .MemErr(err)
  );

  mem_handshake_responder #(.ADDR_W(8), .LATENCY(0)) u_dut0 (
    .Clk(clk), .Clr(rst_n), .MemEnable(en0), .MemRead(rd0), .MemSize(sz0),
    .MemSigned(sg0), .MemAddr(addr0), .MemDataIn(din0), .MemDataOut(dout0),
    .MFC(mfc0), .MemErr(err0)
  );

  // Drives one request on the LATENCY=2 instance; lat = edges from capture to MFC.
  task automatic do_req(input logic r, input logic [1:0] s, input logic sgn,
                        input logic [7:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic mfc_after);
    int cyc;
    @(negedge clk);
    rd = r; sz = s; sg = sgn; addr = a; din = d; en = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (mfc !== 1'b1 && cyc < 50);
    lat = cyc - 1;
    e   = err;
    en  = 1'b0;
    @(negedge clk);
    mfc_after = mfc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 0; rd = 0; sg = 0; sz = 0; addr = 0; din = 0;
    en0 = 0; rd0 = 0; sg0 = 0; sz0 = 0; addr0 = 0; din0 = 0;
    #12;
    vecs++; if (mfc !== 1'b0) begin errs++; $display("FAIL reset_mfc got %b want 0", mfc); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", err); end
    vecs++; if (dout !== 32'h0) begin errs++; $display("FAIL reset_dout got %h want 0", dout); end
    vecs++; if (mfc0 !== 1'b0) begin errs++; $display("FAIL reset_mfc0 got %b want 0", mfc0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    int lat; logic e, ma;
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, lat, e, ma);
    vecs++; if (lat != 3) begin errs++; $display("FAIL word_store_latency got %0d want 3", lat); end
    vecs++; if (e !== 1'b0) begin errs++; $display("FAIL word_store_err got %b want 0", e); end
    vecs++; if (ma !== 1'b0) begin errs++; $display("FAIL word_store_mfc_drop got %b want 0", ma); end
    do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'hDEADBEEF) begin errs++; $display("FAIL word_load got %h want deadbeef", dout); end
    vecs++; if (lat != 3) begin errs++; $display("FAIL word_load_latency got %0d want 3", lat); end
    do_req(1'b1, 2'b00, 1'b0, 8'h10, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'h000000DE) begin errs++; $display("FAIL byte_at_10 got %h want 000000de", dout); end
  endtask

  task automatic test_extension();
    int lat; logic e, ma;
    do_req(1'b1, 2'b00, 1'b1, 8'h11, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'hFFFFFFAD) begin errs++; $display("FAIL sbyte_11 got %h want ffffffad", dout); end
    do_req(1'b1, 2'b00, 1'b0, 8'h11, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'h000000AD) begin errs++; $display("FAIL ubyte_11 got %h want 000000ad", dout); end
    do_req(1'b1, 2'b01, 1'b1, 8'h12, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'hFFFFBEEF) begin errs++; $display("FAIL shalf_12 got %h want ffffbeef", dout); end
    do_req(1'b1, 2'b01, 1'b0, 8'h12, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'h0000BEEF) begin errs++; $display("FAIL uhalf_12 got %h want 0000beef", dout); end
  endtask

  task automatic test_misaligned();
    int lat; logic e, ma;
    do_req(1'b1, 2'b01, 1'b1, 8'h12, 32'h0, lat, e, ma);
    do_req(1'b1, 2'b10, 1'b0, 8'h13, 32'h0, lat, e, ma);
    vecs++; if (e !== 1'b1) begin errs++; $display("FAIL mis_word_err got %b want 1", e); end
    vecs++; if (dout !== 32'hFFFFBEEF) begin errs++; $display("FAIL mis_word_dout got %h want ffffbeef", dout); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL mis_err_clear got %b want 0", err); end
    do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'h11223344, lat, e, ma);
    do_req(1'b0, 2'b01, 1'b0, 8'h21, 32'h0000AAAA, lat, e, ma);
    vecs++; if (e !== 1'b1) begin errs++; $display("FAIL mis_half_err got %b want 1", e); end
    do_req(1'b1, 2'b10, 1'b0, 8'h20, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'h11223344) begin errs++; $display("FAIL mis_half_nowrite got %h want 11223344", dout); end
    vecs++; if (e !== 1'b0) begin errs++; $display("FAIL aligned_word_err got %b want 0", e); end
    do_req(1'b0, 2'b11, 1'b0, 8'h20, 32'h99999999, lat, e, ma);
    vecs++; if (e !== 1'b1) begin errs++; $display("FAIL rsvd_size_err got %b want 1", e); end
    do_req(1'b1, 2'b10, 1'b0, 8'h20, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'h11223344) begin errs++; $display("FAIL rsvd_nowrite got %h want 11223344", dout); end
  endtask

  task automatic test_handshake_hold();
    int cyc, lat; logic e, ma;
    @(negedge clk);
    rd = 1'b0; sz = 2'b00; sg = 1'b0; addr = 8'h50; din = 32'h00000077; en = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (mfc !== 1'b1 && cyc < 50);
    vecs++; if (cyc != 4) begin errs++; $display("FAIL hold_first_mfc got %0d want 4", cyc); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++; if (mfc !== 1'b1) begin errs++; $display("FAIL hold_mfc_%0d got %b want 1", i, mfc); end
    end
    en = 1'b0;
    @(negedge clk);
    vecs++; if (mfc !== 1'b0) begin errs++; $display("FAIL hold_drop got %b want 0", mfc); end
    do_req(1'b1, 2'b00, 1'b0, 8'h50, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'h00000077) begin errs++; $display("FAIL hold_next_load got %h want 00000077", dout); end
    vecs++; if (lat != 3) begin errs++; $display("FAIL hold_next_latency got %0d want 3", lat); end
  endtask

  task automatic test_enable_drop();
    int cyc, lat; logic e, ma;
    @(negedge clk);
    rd = 1'b0; sz = 2'b10; sg = 1'b0; addr = 8'h30; din = 32'hA5A50001; en = 1'b1;
    @(negedge clk);
    cyc = 1;
    en = 1'b0; din = 32'hFFFFFFFF; addr = 8'h34; rd = 1'b1;
    do begin @(negedge clk); cyc++; end while (mfc !== 1'b1 && cyc < 50);
    vecs++; if (cyc != 4) begin errs++; $display("FAIL drop_mfc_time got %0d want 4", cyc); end
    @(negedge clk);
    vecs++; if (mfc !== 1'b0) begin errs++; $display("FAIL drop_mfc_pulse got %b want 0", mfc); end
    do_req(1'b1, 2'b10, 1'b0, 8'h30, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'hA5A50001) begin errs++; $display("FAIL drop_store_data got %h want a5a50001", dout); end
  endtask

  task automatic test_reset_mid();
    int lat; logic e, ma;
    do_req(1'b0, 2'b10, 1'b0, 8'h40, 32'hCAFEF00D, lat, e, ma);
    @(negedge clk);
    rd = 1'b0; sz = 2'b10; sg = 1'b0; addr = 8'h40; din = 32'h12345678; en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0;
    #1;
    vecs++; if (mfc !== 1'b0) begin errs++; $display("FAIL rst_mid_mfc got %b want 0", mfc); end
    vecs++; if (dout !== 32'h0) begin errs++; $display("FAIL rst_mid_dout got %h want 0", dout); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vecs++; if (mfc !== 1'b0) begin errs++; $display("FAIL rst_mid_mfc_hold got %b want 0", mfc); end
    do_req(1'b1, 2'b10, 1'b0, 8'h40, 32'h0, lat, e, ma);
    vecs++; if (dout !== 32'hCAFEF00D) begin errs++; $display("FAIL rst_mid_nowrite got %h want cafef00d", dout); end
    vecs++; if (lat != 3) begin errs++; $display("FAIL rst_mid_next_latency got %0d want 3", lat); end
  endtask

  task automatic test_latency0();
    int cyc;
    for (int op = 0; op < 2; op++) begin
      @(negedge clk);
      rd0 = (op == 1); sz0 = 2'b00; sg0 = 1'b0; addr0 = 8'hFF; din0 = 32'h0000005A; en0 = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (mfc0 !== 1'b1 && cyc < 50);
      vecs++; if (cyc != 2) begin errs++; $display("FAIL lat0_mfc_time_op%0d got %0d want 2", op, cyc); end
      en0 = 1'b0;
      @(negedge clk);
      vecs++; if (mfc0 !== 1'b0) begin errs++; $display("FAIL lat0_mfc_drop_op%0d got %b want 0", op, mfc0); end
    end
    vecs++; if (dout0 !== 32'h0000005A) begin errs++; $display("FAIL lat0_load got %h want 0000005a", dout0); end
    vecs++; if (err0 !== 1'b0) begin errs++; $display("FAIL lat0_err got %b want 0", err0); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_extension();
    test_misaligned();
    test_handshake_hold();
    test_enable_drop();
    test_reset_mid();
    test_latency0();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
